four_digit_led_driver: RTL and testbench
========================================

// Module: four_digit_led_driver
// PURPOSE
//  Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//  - Shows the 16-bit input word as four hex digits: word[15:12] on digit 3 (leftmost) ... word[3:0] on digit 0.
//  - Sits between the datapath (receiver output register) and the board display pins.
//  - One digit at a time drives its anode; a blanking gap around each anode pulse suppresses ghosting.
// PARAMETERS
//  DIV_WIDTH  default 1  width of the prescaler; one refresh step every 2**DIV_WIDTH clk cycles
//                        (1 in simulation; 16 or more on the board).
// PORTS
//  clk    in   1   system clock; single clock domain
//  reset  in   1   asynchronous, active-low reset (reset==0 resets the block)
//  word   in  16   value to display, 4 hex nibbles
//  an3    out  1   anode of digit 3, active-low
//  an2    out  1   anode of digit 2, active-low
//  an1    out  1   anode of digit 1, active-low
//  an0    out  1   anode of digit 0, active-low
//  a..g   out  1   segment cathodes, 7 separate ports, active-low (0 = segment lit)
// BEHAVIOUR
//  - Reset (reset==0, asynchronous):
//    - prescaler=0; step counter=4'hF
//    - an3..an0 = 1 (all digits off); a..g = 1 (blank)
//  - Prescaler: DIV_WIDTH-bit up counter, free-running. tick = (prescaler == all-ones).
//  - Step counter: 4-bit down counter, decremented on every tick; wraps 0 -> F.
//    - One refresh frame = 16 steps = 16*2**DIV_WIDTH clk cycles.
//  - Digit k (k = 3..0) owns counter states 4k+3 .. 4k:
//    - 4k+3: segment register loads decode(word[4k+3:4k]); all anodes 1 (setup gap)
//    - 4k+2, 4k+1: an_k = 0, all other anodes 1; segments held
//    - 4k: all anodes 1 (hold gap); segments held
//  - Anodes and segments are registered outputs, updated on the clk edge where tick=1,
//    from the counter value being entered.
//  - word is sampled only in state 4k+3. A change of word mid-frame affects only digits not yet loaded.
//    No tearing occurs within a single digit.
//  - At most one anode is low at any time. Never two anodes low, even for one cycle.
//  - Decoder (hex -> abcdefg, active-low):
//    - 0=0000001  1=1001111  2=0010010  3=0000110
//    - 4=1001100  5=0100100  6=0100000  7=0001111
//    - 8=0000000  9=0000100  A=0001000  b=1100000
//    - C=0110001  d=1000010  E=0110000  F=0111000
//  - X/undefined word before first assignment: don't care, but anodes must still cycle.
//  - Reset asserted mid-frame: outputs blank immediately (asynchronous). After release the frame restarts at state F.
// STRUCTURE
//  - Shared package/header: segment pattern constants (SEG_0..SEG_F, SEG_BLANK=7'h7F), anode-off constant 4'hF.
//  - Sub-module led_decoder: combinational 4-bit nibble -> 7-bit active-low segments (case statement).
//  - Top: prescaler, step counter, digit-select and nibble mux, output registers.
// TESTING (DIV_WIDTH=1, clk period 20 ns)
//  1. Hold reset=0 for 100 ns -> an3..an0=1111, {a..g}=1111111 throughout.
//  2. Release reset, word=16'h257C -> per frame:
//     - an3 low 2 steps with 0010010
//     - then an2 with 0100100
//     - then an1 with 0001111
//     - then an0 with 0110001
//  3. Check timing -> each anode low exactly 4 clk cycles per 32-cycle frame.
//     - Gaps of 2 cycles before and after each pulse; onehot0 of ~{an3..an0} on every cycle.
//  4. word=16'h0123 then 16'h89AB, change at a frame boundary -> next full frame shows 8,9,A,b.
//     - Change while digit 2 is lit -> digit 2 keeps old value until the next frame.
//  5. Assert reset=0 while an1 is low -> all outputs 1 within the same cycle.
//     - After release, first anode pulse is an3.
//  6. Sweep nibbles 0..F on every digit -> segments match the decoder table above.

Source files
------------

// File: rtl/four_digit_led_driver_pkg.sv
// Shared constants for the four-digit LED driver: active-low segment patterns
// (bit 6 = a ... bit 0 = g), anode-off value, refresh phase encoding.
package four_digit_led_driver_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_OFF    = 4'hF;

    // Low two bits of the step counter: where we are inside one digit's slot.
    typedef enum logic [1:0] {
        PH_HOLD  = 2'd0,
        PH_ON_B  = 2'd1,
        PH_ON_A  = 2'd2,
        PH_SETUP = 2'd3
    } phase_e;

    function automatic logic [3:0] anode_on(input logic [1:0] digit);
        return ~(4'b0001 << digit);
    endfunction

endpackage

// File: rtl/four_digit_led_driver_if.sv
// Nibble-in / segments-out link between the digit mux and the hex decoder.
interface four_digit_led_driver_if;
    logic [3:0] nibble;
    logic [6:0] seg;

    modport master (output nibble, input seg);
    modport slave  (input nibble, output seg);
endinterface

// File: rtl/four_digit_led_driver_decoder.sv
// Combinational hex nibble to active-low abcdefg segment decoder.
module led_decoder
    import four_digit_led_driver_pkg::*;
(
    four_digit_led_driver_if.slave dec
);

    always_comb begin
        dec.seg = SEG_BLANK;
        case (dec.nibble)
            4'h0: dec.seg = SEG_0;
            4'h1: dec.seg = SEG_1;
            4'h2: dec.seg = SEG_2;
            4'h3: dec.seg = SEG_3;
            4'h4: dec.seg = SEG_4;
            4'h5: dec.seg = SEG_5;
            4'h6: dec.seg = SEG_6;
            4'h7: dec.seg = SEG_7;
            4'h8: dec.seg = SEG_8;
            4'h9: dec.seg = SEG_9;
            4'hA: dec.seg = SEG_A;
            4'hB: dec.seg = SEG_B;
            4'hC: dec.seg = SEG_C;
            4'hD: dec.seg = SEG_D;
            4'hE: dec.seg = SEG_E;
            4'hF: dec.seg = SEG_F;
            default: dec.seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/four_digit_led_driver.sv
// Time-multiplexed 4-digit common-anode display driver with blanking gaps
// around every anode pulse; anodes and segments are registered.
module four_digit_led_driver
    import four_digit_led_driver_pkg::*;
#(
    parameter int DIV_WIDTH = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] word,
    output logic        an3,
    output logic        an2,
    output logic        an1,
    output logic        an0,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g
);

    logic [DIV_WIDTH-1:0] presc_q, presc_d;
    logic [3:0]           step_q, step_d;
    logic [3:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 tick;
    logic [1:0]           digit;
    phase_e               phase;
    logic [3:0]           nibble;

    four_digit_led_driver_if dec_if ();

    led_decoder u_decoder (
        .dec (dec_if.slave)
    );

    assign dec_if.nibble = nibble;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            step_q  <= 4'hF;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
        end else begin
            presc_q <= presc_d;
            step_q  <= step_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    always_comb begin
        tick    = &presc_q;
        presc_d = presc_q + 1'b1;
        step_d  = tick ? step_q - 4'd1 : step_q;
    end

    // Outputs follow the step being entered; every step starts with all
    // anodes off, so two digits can never be lit on the same cycle.
    always_comb begin
        digit  = step_d[3:2];
        phase  = phase_e'(step_d[1:0]);
        nibble = word[{digit, 2'b00} +: 4];
        an_d   = an_q;
        seg_d  = seg_q;
        if (tick) begin
            an_d = AN_OFF;
            if (phase == PH_SETUP) begin
                seg_d = dec_if.seg;
            end else if (phase == PH_ON_A || phase == PH_ON_B) begin
                an_d = anode_on(digit);
            end
        end
    end

    assign {an3, an2, an1, an0}  = an_q;
    assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_four_digit_led_driver.sv
// Directed bench for four_digit_led_driver (DIV_WIDTH=1, 20 ns clock):
// vector table for one frame plus hand sequences for timing, word changes and reset.
module tb_four_digit_led_driver;

    typedef struct {
        logic [15:0] word;
        logic [3:0]  step;
        logic [3:0]  an;
        logic [6:0]  seg;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] word = 16'h257C;
    logic        an3, an2, an1, an0;
    logic        a, b, c, d, e, f, g;

    int          checks = 0;
    int          errors = 0;
    logic [6:0]  seg_tab [16];
    logic [6:0]  exp_seg;
    vec_t        frame_tab [16];
    int          low_cnt [4];

    four_digit_led_driver #(.DIV_WIDTH(1)) dut (
        .clk   (clk),
        .reset (reset),
        .word  (word),
        .an3   (an3),
        .an2   (an2),
        .an1   (an1),
        .an0   (an0),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .e     (e),
        .f     (f),
        .g     (g)
    );

    four_digit_led_driver_if dec_if ();

    led_decoder u_dec (
        .dec (dec_if)
    );

    always #10 clk = ~clk;

    // Expected anodes {an3,an2,an1,an0} once step s has been entered
    function automatic logic [3:0] expAn(input logic [3:0] s);
        logic [3:0] r;
        r = 4'hF;
        if (s[1:0] == 2'd2 || s[1:0] == 2'd1) r = ~(4'b0001 << s[3:2]);
        return r;
    endfunction

    task applyStimulus(input logic [15:0] w);
        word = w;
    endtask

    task checkOutput(input string name, input logic [3:0] an_exp,
                     input logic [6:0] seg_exp, input bit check_seg);
        logic [3:0] an_act;
        logic [6:0] seg_act;
        an_act  = {an3, an2, an1, an0};
        seg_act = {a, b, c, d, e, f, g};
        checks++;
        if (an_act !== an_exp || (check_seg && seg_act !== seg_exp)) begin
            errors++;
            $display("[TB] FAIL %s: got an=%b seg=%b, expected an=%b seg=%b",
                     name, an_act, seg_act, an_exp, seg_exp);
        end
    endtask

    // Advance from one step's sample point to the next step's sample point
    task stepOnce();
        repeat (2) @(negedge clk);
    endtask

    // Enter step s: update the segment model, advance, compare
    task runStep(input string name, input logic [3:0] s, input bit check_seg);
        if (s[1:0] == 2'd3) exp_seg = seg_tab[word[{s[3:2], 2'b00} +: 4]];
        stepOnce();
        checkOutput(name, expAn(s), exp_seg, check_seg);
    endtask

    task runFrame(input string name);
        for (int s = 15; s >= 0; s--) runStep(name, 4'(s), 1'b1);
    endtask

    initial begin
        seg_tab[0]  = 7'b0000001;  seg_tab[1]  = 7'b1001111;
        seg_tab[2]  = 7'b0010010;  seg_tab[3]  = 7'b0000110;
        seg_tab[4]  = 7'b1001100;  seg_tab[5]  = 7'b0100100;
        seg_tab[6]  = 7'b0100000;  seg_tab[7]  = 7'b0001111;
        seg_tab[8]  = 7'b0000000;  seg_tab[9]  = 7'b0000100;
        seg_tab[10] = 7'b0001000;  seg_tab[11] = 7'b1100000;
        seg_tab[12] = 7'b0110001;  seg_tab[13] = 7'b1000010;
        seg_tab[14] = 7'b0110000;  seg_tab[15] = 7'b0111000;

        frame_tab[0]  = '{16'h257C, 4'hF, 4'b1111, 7'b0010010};
        frame_tab[1]  = '{16'h257C, 4'hE, 4'b0111, 7'b0010010};
        frame_tab[2]  = '{16'h257C, 4'hD, 4'b0111, 7'b0010010};
        frame_tab[3]  = '{16'h257C, 4'hC, 4'b1111, 7'b0010010};
        frame_tab[4]  = '{16'h257C, 4'hB, 4'b1111, 7'b0100100};
        frame_tab[5]  = '{16'h257C, 4'hA, 4'b1011, 7'b0100100};
        frame_tab[6]  = '{16'h257C, 4'h9, 4'b1011, 7'b0100100};
        frame_tab[7]  = '{16'h257C, 4'h8, 4'b1111, 7'b0100100};
        frame_tab[8]  = '{16'h257C, 4'h7, 4'b1111, 7'b0001111};
        frame_tab[9]  = '{16'h257C, 4'h6, 4'b1101, 7'b0001111};
        frame_tab[10] = '{16'h257C, 4'h5, 4'b1101, 7'b0001111};
        frame_tab[11] = '{16'h257C, 4'h4, 4'b1111, 7'b0001111};
        frame_tab[12] = '{16'h257C, 4'h3, 4'b1111, 7'b0110001};
        frame_tab[13] = '{16'h257C, 4'h2, 4'b1110, 7'b0110001};
        frame_tab[14] = '{16'h257C, 4'h1, 4'b1110, 7'b0110001};
        frame_tab[15] = '{16'h257C, 4'h0, 4'b1111, 7'b0110001};

        // Reset held low: everything dark
        dec_if.nibble = 4'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("reset_hold", 4'hF, 7'h7F, 1'b1);
        end
        reset   = 1'b1;
        exp_seg = 7'h7F;

        // First frame after release begins in state E; digit 3 pulses first
        for (int s = 14; s >= 0; s--) runStep("first_frame", 4'(s), (s < 12));

        // Full frame of 257C from the vector table
        for (int i = 0; i < 16; i++) begin
            applyStimulus(frame_tab[i].word);
            stepOnce();
            checkOutput($sformatf("table_s%0h", frame_tab[i].step),
                        frame_tab[i].an, frame_tab[i].seg, 1'b1);
        end
        exp_seg = 7'b0110001;

        // Per-cycle timing over one frame: pulse width, gaps, one-hot
        for (int k = 0; k < 4; k++) low_cnt[k] = 0;
        for (int n = 1; n <= 32; n++) begin
            int         idx;
            logic [3:0] s;
            logic [3:0] an_act;
            @(negedge clk);
            idx    = (n + 30) % 32;
            s      = 4'(15 - idx / 2);
            an_act = {an3, an2, an1, an0};
            checkOutput($sformatf("timing_c%0d", idx), expAn(s), 7'h00, 1'b0);
            checks++;
            if (!$onehot0(~an_act)) begin
                errors++;
                $display("[TB] FAIL onehot0_c%0d: got an=%b, expected at most one low", idx, an_act);
            end
            for (int k = 0; k < 4; k++) if (!an_act[k]) low_cnt[k]++;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (low_cnt[k] != 4) begin
                errors++;
                $display("[TB] FAIL pulse_width_an%0d: got %0d cycles, expected 4", k, low_cnt[k]);
            end
        end

        // Word changes at frame boundaries
        applyStimulus(16'h0123);
        runFrame("word_0123");
        applyStimulus(16'h89AB);
        runFrame("word_89AB");

        // Word changes while digit 2 is lit: digit 2 keeps 9, digits 1/0 pick up new value
        for (int s = 15; s >= 0; s--) begin
            runStep("mid_change", 4'(s), 1'b1);
            if (s == 10) applyStimulus(16'h0123);
            if (s == 9) checkOutput("mid_change_hold9", 4'b1011, 7'b0000100, 1'b1);
            if (s == 6) checkOutput("mid_change_new2", 4'b1101, 7'b0010010, 1'b1);
        end
        runFrame("after_change");

        // Reset while an1 is lit: blank without waiting for a clock edge
        for (int s = 15; s >= 6; s--) runStep("pre_reset", 4'(s), 1'b1);
        #5 reset = 1'b0;
        #1 checkOutput("async_reset", 4'hF, 7'h7F, 1'b1);
        @(negedge clk);
        checkOutput("reset_mid_hold", 4'hF, 7'h7F, 1'b1);
        @(negedge clk);
        reset   = 1'b1;
        exp_seg = 7'h7F;
        checkOutput("reset_release", 4'hF, 7'h7F, 1'b1);
        for (int s = 14; s >= 0; s--) runStep("post_reset", 4'(s), (s < 12));

        // Every nibble value on every digit through the full display path
        for (int v = 0; v < 16; v++) begin
            applyStimulus({4{4'(v)}});
            runFrame($sformatf("sweep_%0h", v));
        end

        // Decoder on its own through the interface
        for (int v = 0; v < 16; v++) begin
            dec_if.nibble = 4'(v);
            #1;
            checks++;
            if (dec_if.seg !== seg_tab[v]) begin
                errors++;
                $display("[TB] FAIL decoder_%0h: got %b, expected %b", v, dec_if.seg, seg_tab[v]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
